// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared definitions for the pipeline execution controller: command codes,
// controller states and the byte width used by the dump stream.
package pipe_dbg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_DUMP = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP      = 3'd2,
    S_HALTED    = 3'd3,
    S_DUMP_LOAD = 3'd4,
    S_DUMP_SEND = 3'd5
  } state_e;

endpackage

// File: rtl/pipe_exec_ctrl_if.sv
// Debug-unit side bundle of the execution controller: command handshake,
// pipeline control/status, register-file debug port and the dump byte stream.
// master = debug unit / environment, slave = controller.
interface pipe_exec_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);

  logic                          i_cmd_valid;
  logic [1:0]                    i_cmd;
  logic                          o_cmd_ready;
  logic                          is_stop_pipe;
  logic                          o_pipe_enable;
  logic                          o_halted;
  logic [4:0]                    o_reg_rd_addr;
  logic [DATA_W-1:0]             i_reg_rd_data;
  logic [pipe_dbg_pkg::BYTE_W-1:0] o_dump_data;
  logic                          o_dump_valid;
  logic                          i_dump_ready;
  logic [CNT_W-1:0]              o_cycle_count;

  modport master (
    output i_cmd_valid, i_cmd, is_stop_pipe, i_reg_rd_data, i_dump_ready,
    input  o_cmd_ready, o_pipe_enable, o_halted, o_reg_rd_addr,
           o_dump_data, o_dump_valid, o_cycle_count
  );

  modport slave (
    input  i_cmd_valid, i_cmd, is_stop_pipe, i_reg_rd_data, i_dump_ready,
    output o_cmd_ready, o_pipe_enable, o_halted, o_reg_rd_addr,
           o_dump_data, o_dump_valid, o_cycle_count
  );

endinterface

// File: rtl/pipe_exec_ctrl_word_byte_serializer.sv
// Word-to-byte serializer: latches a word on load and presents it LSB first
// as a valid/ready byte stream. The number of bytes to send is given at load
// time (up to WORD_W/8), so one instance can carry both register words and a
// narrower cycle count. done pulses combinationally with the last transfer.
module word_byte_serializer
  import pipe_dbg_pkg::*;
#(
  parameter  int WORD_W  = 32,
  localparam int N_BYTES = WORD_W / BYTE_W,
  localparam int NB_W    = $clog2(N_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [NB_W-1:0]   n_bytes,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              done
);

  logic [WORD_W-1:0] shift;
  logic [NB_W-1:0]   remaining;
  logic              valid;
  logic              xfer;
  logic              last;

  assign xfer       = valid && byte_ready;
  assign last       = (remaining == NB_W'(1));
  assign done       = xfer && last;
  assign byte_data  = shift[BYTE_W-1:0];
  assign byte_valid = valid;

  // Shift register and remaining-byte down-counter; data only moves on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      remaining <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      shift     <= word;
      remaining <= n_bytes;
      valid     <= (n_bytes != '0);
    end else if (xfer) begin
      shift     <= shift >> BYTE_W;
      remaining <= remaining - NB_W'(1);
      if (last) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution controller for the 5-stage pipeline, driven by the debug unit.
// Gates the pipeline enable for RUN/STEP, latches halt from write-back,
// counts enabled cycles and streams a register/cycle-count dump as bytes.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  S_IDLE      | waiting for a command; stop flag ignored
//  S_RUN       | pipeline enabled every cycle until stop is seen
//  S_STEP      | pipeline enabled for exactly one cycle
//  S_HALTED    | program finished; only DUMP (or reset) has an effect
//  S_DUMP_LOAD | latch register[idx] (or the cycle count) into serializer
//  S_DUMP_SEND | bytes of the latched word going out
module pipe_exec_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int N_REGS = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pipe_exec_ctrl_if.slave  bus
);

  localparam int IDX_W     = $clog2(N_REGS + 1);
  localparam int REG_BYTES = DATA_W / BYTE_W;
  localparam int CNT_BYTES = CNT_W / BYTE_W;
  localparam int NB_W      = $clog2(REG_BYTES + 1);
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(N_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state, state_next;
  logic              ret_halted, ret_halted_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [CNT_W-1:0]  count;
  logic              pipe_enable;
  logic              halted;
  logic              cmd_ready;
  logic              accept;
  cmd_e              cmd;
  logic              ser_load;
  logic              ser_done;
  logic [DATA_W-1:0] ser_word;
  logic [NB_W-1:0]   ser_nbytes;

  assign cmd       = cmd_e'(bus.i_cmd);
  assign cmd_ready = (state == S_IDLE) || (state == S_HALTED);
  assign accept    = bus.i_cmd_valid && cmd_ready;

  // Slot CNT_IDX (one past the last register) carries the cycle count.
  assign ser_load   = (state == S_DUMP_LOAD);
  assign ser_word   = (idx == CNT_IDX) ? DATA_W'(count) : bus.i_reg_rd_data;
  assign ser_nbytes = (idx == CNT_IDX) ? NB_W'(CNT_BYTES) : NB_W'(REG_BYTES);

  // Next-state logic: command decode, halt detection and dump sequencing.
  always_comb begin
    state_next      = state;
    ret_halted_next = ret_halted;
    idx_next        = idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_RUN:  state_next = S_RUN;
            CMD_STEP: state_next = S_STEP;
            CMD_DUMP: begin
              state_next      = S_DUMP_LOAD;
              ret_halted_next = 1'b0;
              idx_next        = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.is_stop_pipe) state_next = S_HALTED;
      end
      S_STEP: begin
        state_next = bus.is_stop_pipe ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (accept && cmd == CMD_DUMP) begin
          state_next      = S_DUMP_LOAD;
          ret_halted_next = 1'b1;
          idx_next        = '0;
        end
      end
      S_DUMP_LOAD: begin
        state_next = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (ser_done) begin
          if (idx == CNT_IDX) begin
            state_next = ret_halted ? S_HALTED : S_IDLE;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = S_DUMP_LOAD;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus registered enable/halt outputs decoded from next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      ret_halted  <= 1'b0;
      idx         <= '0;
      pipe_enable <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      ret_halted  <= ret_halted_next;
      idx         <= idx_next;
      pipe_enable <= (state_next == S_RUN) || (state_next == S_STEP);
      if (state_next == S_HALTED) halted <= 1'b1;
    end
  end

  // Enabled-cycle counter; saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (pipe_enable && count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

  word_byte_serializer #(
    .WORD_W (DATA_W)
  ) u_ser (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .load       (ser_load),
    .word       (ser_word),
    .n_bytes    (ser_nbytes),
    .byte_data  (bus.o_dump_data),
    .byte_valid (bus.o_dump_valid),
    .byte_ready (bus.i_dump_ready),
    .done       (ser_done)
  );

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_pipe_enable = pipe_enable;
  assign bus.o_halted      = halted;
  assign bus.o_reg_rd_addr = 5'(idx);
  assign bus.o_cycle_count = count;

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Bench for pipe_exec_ctrl: directed command sequences, a byte scoreboard for
// the dump stream, and a second instance with an 8-bit cycle counter.
module tb_pipe_exec_ctrl;
  import pipe_dbg_pkg::*;

  logic clk;
  logic rst_n;

  pipe_exec_ctrl_if #(.DATA_W(32), .CNT_W(32)) bus ();
  pipe_exec_ctrl_if #(.DATA_W(32), .CNT_W(8))  bus8 ();

  pipe_exec_ctrl #(.N_REGS(32), .DATA_W(32), .CNT_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  pipe_exec_ctrl #(.N_REGS(32), .DATA_W(32), .CNT_W(8)) dut8 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus8)
  );

  // register file model: reg[r] = r * 0x01010101
  assign bus.i_reg_rd_data  = 32'(bus.o_reg_rd_addr) * 32'h0101_0101;
  assign bus8.i_reg_rd_data = 32'(bus8.o_reg_rd_addr) * 32'h0101_0101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int byte_seen = 0;
  int en_cycles = 0;
  int en_rises  = 0;
  logic rand_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    int n;
    n = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    while (!bus.o_cmd_ready && n < 50) begin
      cycle();
      n++;
    end
    if (!bus.o_cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    cycle();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'b00;
  endtask

  task automatic push_dump(input logic [31:0] cnt);
    logic [31:0] w;
    for (int r = 0; r < 32; r++) begin
      w = r * 32'h0101_0101;
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
    for (int b = 0; b < 4; b++) exp_q.push_back(cnt[8*b +: 8]);
  endtask

  task automatic wait_dump_done(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && bus.o_cmd_ready) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0", nm, exp_q.size());
    end
  endtask

  // sink ready: random 50% when enabled, else always ready
  initial begin
    bus.i_dump_ready  = 1'b1;
    bus8.i_dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // enable pulse observer
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_pipe_enable && !prev_en) en_rises++;
      if (bus.o_pipe_enable) en_cycles++;
      prev_en = bus.o_pipe_enable;
    end
  end

  // dump monitor: pops scoreboard on each transfer, checks hold while stalled
  initial begin
    logic       stalled;
    logic [7:0] held;
    logic [7:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("dump_hold_valid", 64'(bus.o_dump_valid), 64'd1);
          check("dump_hold_data", 64'(bus.o_dump_data), 64'(held));
        end
        if (bus.o_dump_valid && bus.i_dump_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_extra_byte: got %0h expected no byte", bus.o_dump_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("dump_byte_%0d", byte_seen), 64'(bus.o_dump_data), 64'(e));
          end
          check("dump_enable_low", 64'(bus.o_pipe_enable), 64'd0);
          byte_seen++;
          stalled = 1'b0;
        end else if (bus.o_dump_valid) begin
          stalled = 1'b1;
          held    = bus.o_dump_data;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = 2'b00;
    bus.is_stop_pipe = 1'b0;
    bus8.i_cmd_valid  = 1'b0;
    bus8.i_cmd        = 2'b00;
    bus8.is_stop_pipe = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) cycle();

    // 1. reset values
    check("rst_enable", 64'(bus.o_pipe_enable), 64'd0);
    check("rst_valid", 64'(bus.o_dump_valid), 64'd0);
    check("rst_halted", 64'(bus.o_halted), 64'd0);
    check("rst_count", 64'(bus.o_cycle_count), 64'd0);
    check("rst_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("rst_addr", 64'(bus.o_reg_rd_addr), 64'd0);
    rst_n = 1'b1;
    cycle();
    send_cmd(CMD_NOP);
    check("nop_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("nop_enable", 64'(bus.o_pipe_enable), 64'd0);
    send_cmd(CMD_RUN);
    check("run_enable_first", 64'(bus.o_pipe_enable), 64'd1);
    check("run_ready_low", 64'(bus.o_cmd_ready), 64'd0);
    repeat (3) cycle();
    check("run_count_3", 64'(bus.o_cycle_count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_enable", 64'(bus.o_pipe_enable), 64'd0);
    check("midrun_rst_count", 64'(bus.o_cycle_count), 64'd0);
    check("midrun_rst_ready", 64'(bus.o_cmd_ready), 64'd1);
    cycle();
    rst_n = 1'b1;
    cycle();

    // 2. three single steps
    en_cycles = 0;
    en_rises  = 0;
    repeat (3) send_cmd(CMD_STEP);
    repeat (3) cycle();
    check("step_en_cycles", 64'(en_cycles), 64'd3);
    check("step_en_pulses", 64'(en_rises), 64'd3);
    check("step_count", 64'(bus.o_cycle_count), 64'd3);
    check("step_idle_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("step_halted", 64'(bus.o_halted), 64'd0);

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();

    // 3. run until stop on the 10th enabled cycle
    en_cycles = 0;
    send_cmd(CMD_RUN);
    repeat (9) cycle();
    check("run_enable_9", 64'(bus.o_pipe_enable), 64'd1);
    bus.is_stop_pipe = 1'b1;
    cycle();
    bus.is_stop_pipe = 1'b0;
    check("halt_count", 64'(bus.o_cycle_count), 64'd10);
    check("halt_enable", 64'(bus.o_pipe_enable), 64'd0);
    check("halt_flag", 64'(bus.o_halted), 64'd1);
    check("halt_en_cycles", 64'(en_cycles), 64'd10);
    check("halt_ready", 64'(bus.o_cmd_ready), 64'd1);
    send_cmd(CMD_RUN);
    repeat (2) cycle();
    check("halt_run_ignored_en", 64'(bus.o_pipe_enable), 64'd0);
    send_cmd(CMD_STEP);
    repeat (2) cycle();
    check("halt_step_ignored_en", 64'(bus.o_pipe_enable), 64'd0);
    check("halt_ignored_count", 64'(bus.o_cycle_count), 64'd10);
    check("halt_still", 64'(bus.o_halted), 64'd1);

    // 4. full dump from HALTED with a stalling sink
    byte_seen  = 0;
    push_dump(32'd10);
    rand_ready = 1'b1;
    send_cmd(CMD_DUMP);
    check("dump_ready_low", 64'(bus.o_cmd_ready), 64'd0);
    wait_dump_done("dump1");
    check("dump1_bytes", 64'(byte_seen), 64'd132);
    check("dump1_return_halted", 64'(bus.o_halted), 64'd1);
    check("dump1_count_frozen", 64'(bus.o_cycle_count), 64'd10);
    cycle();
    check("dump1_valid_low", 64'(bus.o_dump_valid), 64'd0);

    // 5. reset in the middle of a dump, then restart
    byte_seen = 0;
    push_dump(32'd10);
    send_cmd(CMD_DUMP);
    n = 0;
    while (byte_seen < 17 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("dump2_reached_17", 64'(byte_seen >= 17), 64'd1);
    rst_n = 1'b0;
    #1;
    check("dump2_rst_valid", 64'(bus.o_dump_valid), 64'd0);
    exp_q.delete();
    check("dump2_rst_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("dump2_rst_count", 64'(bus.o_cycle_count), 64'd0);
    check("dump2_rst_halted", 64'(bus.o_halted), 64'd0);
    check("dump2_rst_addr", 64'(bus.o_reg_rd_addr), 64'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    byte_seen = 0;
    push_dump(32'd0);
    send_cmd(CMD_DUMP);
    wait_dump_done("dump3");
    check("dump3_bytes", 64'(byte_seen), 64'd132);
    check("dump3_return_idle_halted", 64'(bus.o_halted), 64'd0);
    check("dump3_ready", 64'(bus.o_cmd_ready), 64'd1);
    rand_ready = 1'b0;

    // 6. 8-bit counter saturation
    bus8.i_cmd_valid = 1'b1;
    bus8.i_cmd       = CMD_RUN;
    check("c8_ready", 64'(bus8.o_cmd_ready), 64'd1);
    cycle();
    bus8.i_cmd_valid = 1'b0;
    bus8.i_cmd       = CMD_NOP;
    check("c8_enable", 64'(bus8.o_pipe_enable), 64'd1);
    repeat (200) cycle();
    check("c8_count_200", 64'(bus8.o_cycle_count), 64'd200);
    repeat (100) cycle();
    check("c8_count_sat", 64'(bus8.o_cycle_count), 64'hFF);
    check("c8_still_enabled", 64'(bus8.o_pipe_enable), 64'd1);
    bus8.is_stop_pipe = 1'b1;
    cycle();
    bus8.is_stop_pipe = 1'b0;
    check("c8_halted", 64'(bus8.o_halted), 64'd1);
    check("c8_halt_count", 64'(bus8.o_cycle_count), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
